// File: rtl/uart_obi_host_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_obi_host_if
// Description : Single-word OBI manager/subordinate bundle. It carries the
//               A channel (req/gnt, addr, we, be, wdata, aid) and the
//               R channel (rvalid/rready, rdata, err).
// Modports    : master -> drives the A channel and rready, receives gnt and
//                         the R channel
//               slave  -> the mirror image
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_obi_host_if #(
  parameter int AID_WIDTH = 1
) ();
  logic                 req;
  logic                 gnt;
  logic [31:0]          addr;
  logic                 we;
  logic [3:0]           be;
  logic [31:0]          wdata;
  logic [AID_WIDTH-1:0] aid;
  logic                 rready;
  logic                 rvalid;
  logic [31:0]          rdata;
  logic                 err;

  modport master (
    output req, addr, we, be, wdata, aid, rready,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata, aid, rready,
    output gnt, rvalid, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/uart_obi_host.sv
`default_nettype none
// ============================================================================
// Module      : uart_obi_host
// Description : Byte-stream command bridge to an OBI manager port. A host
//               sends an opcode (0x01 write, 0x02 read), four address bytes
//               and, for writes, four data bytes, all LSB first. The block
//               issues one 32-bit OBI access and replies with a status byte
//               (0x00 ok, 0x01 bus error, 0xFF unknown opcode), followed by
//               four read-data bytes for reads.
// Ports       : clk_i, rst_ni           clock, async active-low reset
//               rx_byte_i/valid/ready   incoming byte stream
//               tx_byte_o/valid/ready   outgoing byte stream
//               obi                     OBI manager port (master modport)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_obi_host #(
  // Maximum clk cycles allowed between bytes inside a command; 0 disables.
  parameter int unsigned IDLE_TIMEOUT = 32'd1000000
) (
  input  wire               clk_i,
  input  wire               rst_ni,
  input  wire  [7:0]        rx_byte_i,
  input  wire               rx_valid_i,
  output logic              rx_ready_o,
  output logic [7:0]        tx_byte_o,
  output logic              tx_valid_o,
  input  wire               tx_ready_i,
  uart_obi_host_if.master   obi
);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_addr    = 3'd1;
  localparam logic [2:0] c_wdata   = 3'd2;
  localparam logic [2:0] c_req     = 3'd3;
  localparam logic [2:0] c_resp    = 3'd4;
  localparam logic [2:0] c_tx_stat = 3'd5;
  localparam logic [2:0] c_tx_data = 3'd6;

  localparam logic [7:0]  c_op_write    = 8'h01;
  localparam logic [7:0]  c_op_read     = 8'h02;
  localparam logic [7:0]  c_st_ok       = 8'h00;
  localparam logic [7:0]  c_st_bus_err  = 8'h01;
  localparam logic [7:0]  c_st_bad_op   = 8'hFF;
  localparam logic [31:0] c_timeout_max = 32'(IDLE_TIMEOUT) - 32'd1;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic        r_is_write;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [7:0]  r_status;
  logic [31:0] r_timer;

  logic        w_rx_fire;
  logic        w_tx_fire;
  logic        w_last_byte;
  logic        w_timeout;
  logic        w_known_op;
  logic [4:0]  w_byte_sel;

  assign w_rx_fire   = rx_valid_i && rx_ready_o;
  assign w_tx_fire   = tx_valid_o && tx_ready_i;
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_known_op  = (rx_byte_i == c_op_write) || (rx_byte_i == c_op_read);
  assign w_byte_sel  = {r_byte_cnt, 3'b000};
  // Abandon a partial command once the line has been silent for IDLE_TIMEOUT
  // cycles; a byte arriving in the final cycle still counts.
  assign w_timeout   = (IDLE_TIMEOUT != 0) && !w_rx_fire && (r_timer == c_timeout_max);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: begin
        if (w_rx_fire) begin
          w_next_state = w_known_op ? c_addr : c_tx_stat;
        end
      end
      c_addr: begin
        if (w_rx_fire && w_last_byte) begin
          w_next_state = r_is_write ? c_wdata : c_req;
        end else if (w_timeout) begin
          w_next_state = c_idle;
        end
      end
      c_wdata: begin
        if (w_rx_fire && w_last_byte) begin
          w_next_state = c_req;
        end else if (w_timeout) begin
          w_next_state = c_idle;
        end
      end
      c_req: begin
        if (obi.gnt) begin
          w_next_state = c_resp;
        end
      end
      c_resp: begin
        if (obi.rvalid) begin
          w_next_state = c_tx_stat;
        end
      end
      c_tx_stat: begin
        if (w_tx_fire) begin
          // Reads (even failed ones) follow up with the data word.
          w_next_state = (!r_is_write && (r_status != c_st_bad_op)) ? c_tx_data : c_idle;
        end
      end
      c_tx_data: begin
        if (w_tx_fire && w_last_byte) begin
          w_next_state = c_idle;
        end
      end
      default: w_next_state = c_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_byte_o  = 8'h00;
    obi.req    = 1'b0;
    obi.addr   = r_addr;
    obi.we     = r_is_write;
    obi.be     = 4'hF;
    obi.wdata  = r_is_write ? r_wdata : 32'h0;
    obi.aid    = '0;
    obi.rready = 1'b0;
    case (r_state)
      c_idle, c_addr, c_wdata: rx_ready_o = 1'b1;
      c_req:                   obi.req    = 1'b1;
      c_resp:                  obi.rready = 1'b1;
      c_tx_stat: begin
        tx_valid_o = 1'b1;
        tx_byte_o  = r_status;
      end
      c_tx_data: begin
        tx_valid_o = 1'b1;
        tx_byte_o  = r_rdata[w_byte_sel +: 8];
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Command/response datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_is_write <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_status   <= 8'h00;
      r_timer    <= 32'h0;
    end else begin
      // Inter-byte timer runs only while a command is being collected.
      if ((r_state == c_addr) || (r_state == c_wdata)) begin
        r_timer <= w_rx_fire ? 32'h0 : r_timer + 32'd1;
      end else begin
        r_timer <= 32'h0;
      end

      case (r_state)
        c_idle: begin
          if (w_rx_fire) begin
            r_is_write <= (rx_byte_i == c_op_write);
            r_byte_cnt <= 2'd0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            if (!w_known_op) begin
              r_status <= c_st_bad_op;
            end
          end
        end
        c_addr: begin
          if (w_rx_fire) begin
            r_addr[w_byte_sel +: 8] <= rx_byte_i;
            r_byte_cnt              <= r_byte_cnt + 2'd1;
          end
        end
        c_wdata: begin
          if (w_rx_fire) begin
            r_wdata[w_byte_sel +: 8] <= rx_byte_i;
            r_byte_cnt               <= r_byte_cnt + 2'd1;
          end
        end
        c_resp: begin
          if (obi.rvalid) begin
            r_rdata  <= obi.rdata;
            r_status <= obi.err ? c_st_bus_err : c_st_ok;
          end
        end
        c_tx_stat: begin
          if (w_tx_fire) begin
            r_byte_cnt <= 2'd0;
          end
        end
        c_tx_data: begin
          if (w_tx_fire) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_obi_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_obi_host
// Description : Directed testbench for uart_obi_host. An OBI subordinate
//               model with programmable gnt/rvalid delays answers requests,
//               a byte sink with programmable backpressure collects replies,
//               and every expected value is written out by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_obi_host;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  always #5 clk = ~clk;

  uart_obi_host_if #(.AID_WIDTH(1)) bus ();

  uart_obi_host #(.IDLE_TIMEOUT(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .rx_byte_i  (rx_byte),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_byte_o  (tx_byte),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .obi        (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // OBI subordinate model
  // --------------------------------------------------------------------------
  int          g_delay = 0;
  int          r_delay = 0;
  logic [31:0] rsp_data = 32'h0;
  logic        rsp_err = 1'b0;
  bit          inject_rvalid = 1'b0;
  int          req_count = 0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic        last_we = 1'b0;
  logic [3:0]  last_be = 4'h0;
  int          last_stall = 0;
  int          stab_err = 0;
  int          req_rise_cyc = 0;
  int          gnt_cyc = 0;

  initial begin : slave_model
    bit          pend, granted, prev_req;
    int          wcnt, rcnt, stall;
    logic [68:0] cap;
    pend = 0; prev_req = 0; wcnt = 0; rcnt = 0; stall = 0; cap = '0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        bus.gnt = 1'b0; bus.rvalid = 1'b0;
        pend = 0; prev_req = 0; wcnt = 0;
      end else begin
        granted    = bus.gnt;
        bus.gnt    = 1'b0;
        bus.rvalid = 1'b0;
        if (inject_rvalid) begin
          bus.rvalid = 1'b1; bus.rdata = 32'hBAD0BAD0; bus.err = 1'b1;
          inject_rvalid = 1'b0;
        end
        if (granted) begin
          pend = 1; rcnt = 0;
        end
        if (pend) begin
          if (rcnt == r_delay) begin
            bus.rvalid = 1'b1; bus.rdata = rsp_data; bus.err = rsp_err;
            pend = 0;
          end else begin
            rcnt++;
          end
        end else if (bus.req) begin
          if (!prev_req) begin
            cap = {bus.addr, bus.wdata, bus.we, bus.be};
            req_rise_cyc = cyc; wcnt = 0; stall = 0;
          end else if ({bus.addr, bus.wdata, bus.we, bus.be} != cap) begin
            stab_err++;
          end
          if (wcnt == g_delay) begin
            bus.gnt = 1'b1; gnt_cyc = cyc; req_count++;
            last_addr = bus.addr; last_wdata = bus.wdata;
            last_we = bus.we; last_be = bus.be; last_stall = stall;
          end else begin
            wcnt++; stall++;
          end
        end
        prev_req = bus.req;
      end
    end
  end

  // --------------------------------------------------------------------------
  // TX byte sink
  // --------------------------------------------------------------------------
  int         tx_stall = 0;
  logic [7:0] txq[$];
  int         tx_stab_err = 0;
  int         tx_drop_err = 0;
  int         rx_busy_err = 0;
  int         stat_cyc = 0;

  initial begin : tx_sink
    int         scnt;
    bit         prev_v, prev_r;
    logic [7:0] held;
    scnt = 0; prev_v = 0; prev_r = 0; held = 8'h00;
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        tx_ready = 1'b0; scnt = 0; prev_v = 0; prev_r = 0;
      end else begin
        if (prev_v && !prev_r && !tx_valid) tx_drop_err++;
        if (tx_valid && rx_ready) rx_busy_err++;
        if (tx_valid && !prev_v) stat_cyc = cyc;
        if (tx_valid) begin
          if (prev_v && !prev_r && (tx_byte != held)) tx_stab_err++;
          if (scnt < tx_stall) begin
            tx_ready = 1'b0; scnt++;
          end else begin
            tx_ready = 1'b1; txq.push_back(tx_byte); scnt = 0;
          end
          held = tx_byte;
        end else begin
          tx_ready = 1'b0;
        end
        prev_v = tx_valid;
        prev_r = tx_ready;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all called at a falling edge)
  // --------------------------------------------------------------------------
  int last_acc_cyc = 0;

  task automatic send_byte(input logic [7:0] b);
    int t;
    rx_byte  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("rx_accept_timeout", 32'(rx_ready), 32'h1);
    last_acc_cyc = cyc + 1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_reply(input string tag, input logic [7:0] st,
                              input logic [31:0] data, input bit with_data);
    int n, t;
    n = with_data ? 5 : 1;
    t = 0;
    while (txq.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_tx_count"}, 32'(txq.size()), 32'(n));
    check({tag, "_status"}, {24'h0, txq[0]}, {24'h0, st});
    if (with_data) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("%s_data%0d", tag, i), {24'h0, txq[i+1]}, {24'h0, data[8*i +: 8]});
    end
    txq.delete();
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  int base;

  initial begin : main
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'h1);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_byte", 32'(tx_byte), 32'h0);
    check("rst_req", 32'(bus.req), 32'h0);
    #2 rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // Write with zero-wait gnt/rvalid
    base = req_count;
    send_byte(8'h01); send_word(32'h30000010); send_word(32'hDEADBEEF);
    expect_reply("wr", 8'h00, 32'h0, 1'b0);
    check("wr_req_count", 32'(req_count - base), 32'd1);
    check("wr_addr", last_addr, 32'h30000010);
    check("wr_we", 32'(last_we), 32'h1);
    check("wr_be", 32'(last_be), 32'hF);
    check("wr_wdata", last_wdata, 32'hDEADBEEF);
    check("wr_req_latency", 32'(req_rise_cyc), 32'(last_acc_cyc));
    check("wr_stat_latency", 32'(stat_cyc - gnt_cyc), 32'd2);

    // Read with gnt after 3 stall cycles and rvalid 2 cycles later
    base = req_count; g_delay = 3; r_delay = 2; rsp_data = 32'h12345678; rsp_err = 1'b0;
    send_byte(8'h02); send_word(32'h30000004);
    expect_reply("rd", 8'h00, 32'h12345678, 1'b1);
    check("rd_req_count", 32'(req_count - base), 32'd1);
    check("rd_addr", last_addr, 32'h30000004);
    check("rd_we", 32'(last_we), 32'h0);
    check("rd_wdata", last_wdata, 32'h0);
    check("rd_stall_cycles", 32'(last_stall), 32'd3);
    check("rd_req_stable", 32'(stab_err), 32'd0);

    // Read returning a bus error
    g_delay = 0; r_delay = 0; rsp_data = 32'h0; rsp_err = 1'b1;
    send_byte(8'h02); send_word(32'h00000008);
    expect_reply("err", 8'h01, 32'h0, 1'b1);

    // Unknown opcode, then a read decoded straight after it
    base = req_count; rsp_err = 1'b0; rsp_data = 32'h0BADC0DE;
    send_byte(8'h7F);
    expect_reply("badop", 8'hFF, 32'h0, 1'b0);
    check("badop_no_req", 32'(req_count - base), 32'd0);
    send_byte(8'h02); send_word(32'h00000100);
    expect_reply("after_badop", 8'h00, 32'h0BADC0DE, 1'b1);
    check("after_badop_addr", last_addr, 32'h00000100);

    // Reply under TX backpressure
    tx_stall = 5; rsp_data = 32'hA5C31E7F;
    send_byte(8'h02); send_word(32'h0000000C);
    expect_reply("bp", 8'h00, 32'hA5C31E7F, 1'b1);
    check("bp_tx_stable", 32'(tx_stab_err), 32'd0);
    check("bp_tx_no_drop", 32'(tx_drop_err), 32'd0);
    check("bp_rx_busy", 32'(rx_busy_err), 32'd0);
    tx_stall = 0;

    // Inter-byte timeout drops a partial write
    base = req_count; rsp_data = 32'hCAFEF00D;
    send_byte(8'h01); send_byte(8'h10);
    repeat (20) @(negedge clk);
    check("to_no_req", 32'(req_count - base), 32'd0);
    check("to_no_tx", 32'(txq.size()), 32'd0);
    send_byte(8'h02); send_word(32'h00000000);
    expect_reply("to_rd", 8'h00, 32'hCAFEF00D, 1'b1);
    check("to_req_count", 32'(req_count - base), 32'd1);
    check("to_addr", last_addr, 32'h00000000);
    check("to_we", 32'(last_we), 32'h0);

    // Reset while a request waits for gnt
    base = req_count; g_delay = 1000;
    send_byte(8'h02); send_word(32'h30000040);
    check("mid_req_pending", 32'(bus.req), 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus.req), 32'h0);
    check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("mid_rst_rx_ready", 32'(rx_ready), 32'h1);
    @(negedge clk);
    g_delay = 0;
    #2 rst_ni = 1'b1;
    inject_rvalid = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_rvalid_no_tx", 32'(txq.size()), 32'd0);
    check("stray_rvalid_idle", 32'(rx_ready), 32'h1);
    check("mid_rst_no_gnt", 32'(req_count - base), 32'd0);
    send_byte(8'h01); send_word(32'h30000020); send_word(32'h11223344);
    expect_reply("post_rst_wr", 8'h00, 32'h0, 1'b0);
    check("post_rst_addr", last_addr, 32'h30000020);
    check("post_rst_wdata", last_wdata, 32'h11223344);
    check("post_rst_we", 32'(last_we), 32'h1);
    check("post_rst_req_count", 32'(req_count - base), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed no completion, expected completion within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/uart_obi_host.md
Name: uart_obi_host

Overview:
Byte-level command bridge that turns a serial byte stream into OBI manager transactions. It is the initiator counterpart to the uart OBI subordinate: a host PC drives the chip's bus through a UART link. Bytes arrive from an RX byte source and are decoded into single-word OBI read/write requests. Status and read data go back as bytes to a TX byte sink. Bit-level serialization is outside this block.

Parameters:
ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration; addr/data width fixed at 32
obi_req_t, logic, OBI request struct type (driven)
obi_rsp_t, logic, OBI response struct type (received)
IdleTimeout, 32'd1000000, max clk cycles between bytes inside one command; 0 disables

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
rx_byte_i  input  8  received byte
rx_valid_i  input  1  rx_byte_i valid
rx_ready_o  output  1  block accepts byte (transfer when valid&&ready)
tx_byte_o  output  8  byte to transmit
tx_valid_o  output  1  tx_byte_o valid
tx_ready_i  input  1  sink accepts byte
obi_req_o  output  obi_req_t  a.addr, a.we, a.be, a.wdata, a.aid, req, rready
obi_rsp_i  input  obi_rsp_t  r.rdata, r.err, gnt, rvalid

Behaviour:
- Reset: state IDLE; req=0, tx_valid_o=0, tx_byte_o=0, addr/wdata/rdata/counters=0; rx_ready_o=1 (IDLE).
- Command format: opcode byte; 0x01=write, 0x02=read. Then 4 address bytes, LSB first. Write adds 4 wdata bytes, LSB first.
- States: IDLE, ADDR, WDATA, REQ, RESP, TX_STAT, TX_DATA.
- IDLE: rx_ready_o=1.
  - 0x01/0x02 -> ADDR, byte_cnt=0.
  - Any other opcode -> TX_STAT with status 0xFF; no OBI access.
- ADDR: rx_ready_o=1. Each accepted byte is stored at addr[8*byte_cnt +: 8]. After the 4th byte: write -> WDATA, read -> REQ.
- WDATA: same as ADDR into wdata. After the 4th byte -> REQ.
- rx_ready_o=0 in REQ, RESP, TX_STAT, TX_DATA.
- REQ: req=1, a.addr=addr, a.we=(opcode==0x01), a.be=4'hF, a.wdata=wdata (0 for reads), a.aid=0.
  - Fields are held stable until gnt.
  - On req&&gnt -> RESP; req drops the next cycle.
- RESP: rready=1 always. rvalid is sampled only in RESP. On rvalid:
  - latch rdata;
  - status = r.err ? 0x01 : 0x00;
  - -> TX_STAT.
- TX_STAT: tx_valid_o=1, tx_byte_o=status, held until tx_ready_i.
  - On handshake: read (and not 0xFF) -> TX_DATA, byte_cnt=0; otherwise -> IDLE.
- TX_DATA: send rdata bytes LSB first, 4 bytes. Each byte is held until tx_ready_i. After the 4th -> IDLE.
  - rdata is sent even when status=0x01.
- Minimum latency: write command last byte accepted -> req=1 next cycle. Zero-wait gnt/rvalid -> status tx_valid_o 2 cycles after the gnt cycle.
- Timeout: in ADDR/WDATA a counter clears on every accepted byte and increments otherwise.
  - When counter reaches IdleTimeout-1 with no byte that cycle -> IDLE; partial command discarded; no OBI access, no tx byte.
  - Counter is inactive in other states. IdleTimeout=0 never times out.
- No timeout on gnt/rvalid: the block waits indefinitely.
- Back-to-back: the next opcode is accepted in the first IDLE cycle after the final tx handshake.
- tx_valid_o never drops without tx_ready_i. tx_byte_o is stable while tx_valid_o && !tx_ready_i.
- Async reset mid-transaction returns to reset state immediately. A pending OBI response after reset is ignored: RESP is not entered without a new gnt.

Test Plan:
- Write: bytes 01 10 00 00 30 EF BE AD DE, gnt/rvalid zero-wait -> one req, addr=0x30000010, we=1, be=F, wdata=0xDEADBEEF; tx bytes: 00.
- Read: bytes 02 04 00 00 30, gnt after 3 cycles, rvalid after 2 more, rdata=0x12345678 -> req held stable 3 cycles; tx: 00 78 56 34 12.
- Error: read with r.err=1, rdata=0 -> tx: 01 00 00 00 00. Unknown opcode 0x7F -> tx: FF, no req, next byte decoded as opcode.
- TX backpressure: tx_ready_i low 5 cycles per byte during read reply -> each byte stable while stalled; rx_ready_o=0 throughout; exactly 5 tx bytes.
- Timeout, IdleTimeout=16: bytes 01 10 then 20-cycle gap, then 02 00 00 00 00 -> first command dropped, no write; one read to 0x00000000, tx 00 + 4 data bytes.
- Reset mid-REQ (req=1, no gnt): assert rst_ni low 1 cycle -> req=0, tx_valid_o=0, rx_ready_o=1; a following full write completes normally.
